// File: rtl/pinwheel_hart_sched.sv
// Purpose : round-robin slot scheduler for the barrel pipeline; holds SLOT_COUNT
//           HPC words {hart[7:0], pc} and offers one eligible slot per cycle to fetch.
// Latency : offer is registered (state/inputs at cycle t -> offer during t+1);
//           a retire or debug start at t makes the slot offerable during t+1.
// Backpressure: valid/ready; an offer is held stable while valid && !ready and
//           is withdrawn only if debug parks the offered slot. Valid never depends on ready.
//
// Ports:
//   clock, tick_reset_in                 clock, synchronous active-high reset
//   sig_fetch_valid/_hpc/_slot           registered offer to fetch (hpc/slot 0 when idle)
//   tock_fetch_ready                     fetch accepts the offer this cycle
//   tock_ret_valid/_slot/_hpc            next-HPC write-back from stage B
//   tock_dbg_wren/_slot/_hpc             debug load of a slot HPC (pc==0 parks it)
//   sig_active_mask                      bit s set while slot s holds a non-zero pc
//   sig_stray_ret                        one-cycle pulse after a retire for a slot not in flight
// Build option PINWHEEL_SCHED_PERF_EN adds per-slot retire counters read through
//   tock_perf_slot / sig_perf_count (combinational read).

module pinwheel_hart_sched #(
  parameter int                   SLOT_COUNT = 4,
  parameter int                   PC_BITS    = 24,
  parameter logic [8+PC_BITS-1:0] RESET_HPC  = 32'h00400000
) (
  input  logic                          clock,
  input  logic                          tick_reset_in,
  output logic                          sig_fetch_valid,
  output logic [8+PC_BITS-1:0]          sig_fetch_hpc,
  output logic [$clog2(SLOT_COUNT)-1:0] sig_fetch_slot,
  input  logic                          tock_fetch_ready,
  input  logic                          tock_ret_valid,
  input  logic [$clog2(SLOT_COUNT)-1:0] tock_ret_slot,
  input  logic [8+PC_BITS-1:0]          tock_ret_hpc,
  input  logic                          tock_dbg_wren,
  input  logic [$clog2(SLOT_COUNT)-1:0] tock_dbg_slot,
  input  logic [8+PC_BITS-1:0]          tock_dbg_hpc,
  output logic [SLOT_COUNT-1:0]         sig_active_mask,
  output logic                          sig_stray_ret
`ifdef PINWHEEL_SCHED_PERF_EN
  ,
  input  logic [$clog2(SLOT_COUNT)-1:0] tock_perf_slot,
  output logic [31:0]                   sig_perf_count
`endif
);

  localparam int SB = $clog2(SLOT_COUNT);

  typedef logic [SB-1:0] slot_t;

  typedef struct packed {
    logic [7:0]         hart;
    logic [PC_BITS-1:0] pc;
  } hpc_t;

  hpc_t                  slot_q [SLOT_COUNT];
  hpc_t                  slot_d [SLOT_COUNT];
  logic [SLOT_COUNT-1:0] inflight_q, inflight_d;
  slot_t                 rr_q, rr_d;
  logic                  offer_vld_q, offer_vld_d;
  hpc_t                  offer_hpc_q, offer_hpc_d;
  slot_t                 offer_slot_q, offer_slot_d;
  logic                  stray_q, stray_d;

  logic                  accept;
  logic                  park_offer;
  logic [SLOT_COUNT-1:0] ret_land;
  logic [SLOT_COUNT-1:0] dbg_hit;
  logic [SLOT_COUNT-1:0] elig;
  logic                  pick_found;
  slot_t                 pick_slot;
  hpc_t                  pick_hpc;
  hpc_t                  dbg_word;

  assign dbg_word = tock_dbg_hpc;

  always_comb begin
    accept     = offer_vld_q && tock_fetch_ready;
    ret_land   = '0;
    dbg_hit    = '0;
    elig       = '0;
    inflight_d = inflight_q;
    for (int s = 0; s < SLOT_COUNT; s++) begin
      slot_d[s]   = slot_q[s];
      dbg_hit[s]  = tock_dbg_wren && (tock_dbg_slot == slot_t'(s));
      ret_land[s] = tock_ret_valid && (tock_ret_slot == slot_t'(s)) && inflight_q[s];
      if (accept && (offer_slot_q == slot_t'(s))) begin
        inflight_d[s] = 1'b1;
      end
      if (ret_land[s]) begin
        slot_d[s]     = tock_ret_hpc;
        inflight_d[s] = 1'b0;
      end
      // Debug overrides the HPC but leaves in-flight tracking alone, so a late
      // retire can still land on top of it; software parks before restarting.
      if (dbg_hit[s]) begin
        slot_d[s] = dbg_word;
      end
      elig[s] = (slot_d[s].pc != '0) && !inflight_d[s];
    end

    stray_d = tock_ret_valid && (ret_land == '0);
    rr_d    = accept ? offer_slot_q : rr_q;

    // First eligible slot strictly after the rr pointer, wrapping. Eligibility
    // uses next-state so the just-accepted slot is excluded and fresh retires
    // are offered straight away.
    pick_found = 1'b0;
    pick_slot  = '0;
    pick_hpc   = '0;
    for (int k = 1; k <= SLOT_COUNT; k++) begin
      for (int s = 0; s < SLOT_COUNT; s++) begin
        if (!pick_found && elig[s] && (((int'(rr_d) + k) % SLOT_COUNT) == s)) begin
          pick_found = 1'b1;
          pick_slot  = slot_t'(s);
          pick_hpc   = slot_d[s];
        end
      end
    end

    park_offer = tock_dbg_wren && (tock_dbg_slot == offer_slot_q) && (dbg_word.pc == '0);

    offer_vld_d  = pick_found;
    offer_hpc_d  = pick_found ? pick_hpc : '0;
    offer_slot_d = pick_slot;
    if (offer_vld_q && !tock_fetch_ready) begin
      if (park_offer) begin
        offer_vld_d  = 1'b0;
        offer_hpc_d  = '0;
        offer_slot_d = '0;
      end else begin
        offer_vld_d  = offer_vld_q;
        offer_hpc_d  = offer_hpc_q;
        offer_slot_d = offer_slot_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      for (int s = 0; s < SLOT_COUNT; s++) begin
        if (s == 0) begin
          slot_q[s] <= RESET_HPC;
        end else begin
          slot_q[s] <= '0;
        end
      end
      inflight_q   <= '0;
      rr_q         <= slot_t'(SLOT_COUNT - 1);
      offer_vld_q  <= 1'b0;
      offer_hpc_q  <= '0;
      offer_slot_q <= '0;
      stray_q      <= 1'b0;
    end else begin
      for (int s = 0; s < SLOT_COUNT; s++) begin
        slot_q[s] <= slot_d[s];
      end
      inflight_q   <= inflight_d;
      rr_q         <= rr_d;
      offer_vld_q  <= offer_vld_d;
      offer_hpc_q  <= offer_hpc_d;
      offer_slot_q <= offer_slot_d;
      stray_q      <= stray_d;
    end
  end

  always_comb begin
    sig_active_mask = '0;
    for (int s = 0; s < SLOT_COUNT; s++) begin
      sig_active_mask[s] = (slot_q[s].pc != '0);
    end
  end

  assign sig_fetch_valid = offer_vld_q;
  assign sig_fetch_hpc   = offer_hpc_q;
  assign sig_fetch_slot  = offer_slot_q;
  assign sig_stray_ret   = stray_q;

`ifdef PINWHEEL_SCHED_PERF_EN
  logic [31:0] perf_q [SLOT_COUNT];

  // Counts retires that actually land; a debug write restarts the slot's count.
  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      for (int s = 0; s < SLOT_COUNT; s++) begin
        perf_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SLOT_COUNT; s++) begin
        if (dbg_hit[s]) begin
          perf_q[s] <= '0;
        end else if (ret_land[s]) begin
          perf_q[s] <= perf_q[s] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    sig_perf_count = '0;
    for (int s = 0; s < SLOT_COUNT; s++) begin
      if (tock_perf_slot == slot_t'(s)) begin
        sig_perf_count = perf_q[s];
      end
    end
  end
`endif

endmodule

// File: tb/tb_pinwheel_hart_sched.sv
// Purpose : self-checking bench for pinwheel_hart_sched (SLOT_COUNT=4, PC_BITS=24).
// Latency : inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: ready patterns are driven by the vector tables and the scoreboard loop.

module tb_pinwheel_hart_sched;

  logic        clock;
  logic        tick_reset_in;
  logic        sig_fetch_valid;
  logic [31:0] sig_fetch_hpc;
  logic [1:0]  sig_fetch_slot;
  logic        tock_fetch_ready;
  logic        tock_ret_valid;
  logic [1:0]  tock_ret_slot;
  logic [31:0] tock_ret_hpc;
  logic        tock_dbg_wren;
  logic [1:0]  tock_dbg_slot;
  logic [31:0] tock_dbg_hpc;
  logic [3:0]  sig_active_mask;
  logic        sig_stray_ret;
`ifdef PINWHEEL_SCHED_PERF_EN
  logic [1:0]  tock_perf_slot;
  logic [31:0] sig_perf_count;
`endif

  pinwheel_hart_sched #(
    .SLOT_COUNT(4),
    .PC_BITS   (24),
    .RESET_HPC (32'h00400000)
  ) dut (
    .clock           (clock),
    .tick_reset_in   (tick_reset_in),
    .sig_fetch_valid (sig_fetch_valid),
    .sig_fetch_hpc   (sig_fetch_hpc),
    .sig_fetch_slot  (sig_fetch_slot),
    .tock_fetch_ready(tock_fetch_ready),
    .tock_ret_valid  (tock_ret_valid),
    .tock_ret_slot   (tock_ret_slot),
    .tock_ret_hpc    (tock_ret_hpc),
    .tock_dbg_wren   (tock_dbg_wren),
    .tock_dbg_slot   (tock_dbg_slot),
    .tock_dbg_hpc    (tock_dbg_hpc),
    .sig_active_mask (sig_active_mask),
    .sig_stray_ret   (sig_stray_ret)
`ifdef PINWHEEL_SCHED_PERF_EN
    ,
    .tock_perf_slot  (tock_perf_slot),
    .sig_perf_count  (sig_perf_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [1:0]  rs;
    logic [31:0] rh;
    logic        dw;
    logic [1:0]  ds;
    logic [31:0] dh;
    logic        e_vld;
    logic [31:0] e_hpc;
    logic [1:0]  e_slot;
    logic [3:0]  e_mask;
    logic        e_stray;
  } vec_t;

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] hpc;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl_a [11];
  vec_t tbl_c [8];
  exp_t sb_q [$];
  exp_t front;
  exp_t ret_item;
  logic ret_pend;
  logic [3:0] exp_mask;
  logic [3:0] exp_mask_next;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [1:0] rs, input logic [31:0] rh,
                              input logic dw, input logic [1:0] ds, input logic [31:0] dh,
                              input logic ev, input logic [31:0] eh, input logic [1:0] es,
                              input logic [3:0] em, input logic est);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rs = rs; v.rh = rh;
    v.dw = dw; v.ds = ds; v.dh = dh;
    v.e_vld = ev; v.e_hpc = eh; v.e_slot = es; v.e_mask = em; v.e_stray = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    tick_reset_in    = v.rst;
    tock_fetch_ready = v.rdy;
    tock_ret_valid   = v.rv;
    tock_ret_slot    = v.rs;
    tock_ret_hpc     = v.rh;
    tock_dbg_wren    = v.dw;
    tock_dbg_slot    = v.ds;
    tock_dbg_hpc     = v.dh;
    step();
    check($sformatf("%s%0d_vld", tag, idx),   32'(sig_fetch_valid), 32'(v.e_vld));
    check($sformatf("%s%0d_hpc", tag, idx),   sig_fetch_hpc,        v.e_hpc);
    check($sformatf("%s%0d_slot", tag, idx),  32'(sig_fetch_slot),  32'(v.e_slot));
    check($sformatf("%s%0d_mask", tag, idx),  32'(sig_active_mask), 32'(v.e_mask));
    check($sformatf("%s%0d_stray", tag, idx), 32'(sig_stray_ret),   32'(v.e_stray));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tick_reset_in = 1'b1; tock_fetch_ready = 1'b0;
    tock_ret_valid = 1'b0; tock_ret_slot = '0; tock_ret_hpc = '0;
    tock_dbg_wren = 1'b0; tock_dbg_slot = '0; tock_dbg_hpc = '0;
`ifdef PINWHEEL_SCHED_PERF_EN
    tock_perf_slot = '0;
`endif

    //              rst rdy rv rs  rh            dw ds  dh            vld hpc           slot mask stray
    tbl_a[0]  = mk(1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 4'h1, 0);
    tbl_a[1]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00400000, 0, 4'h1, 0);
    tbl_a[2]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 4'h1, 0);
    tbl_a[3]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 4'h1, 0);
    tbl_a[4]  = mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h01000100, 1, 32'h01000100, 1, 4'h3, 0);
    tbl_a[5]  = mk(0, 0, 0, 0, 32'h0,        1, 2, 32'h02000200, 1, 32'h01000100, 1, 4'h7, 0);
    tbl_a[6]  = mk(0, 0, 1, 0, 32'h00400004, 0, 0, 32'h0,        1, 32'h01000100, 1, 4'h7, 0);
    tbl_a[7]  = mk(0, 0, 1, 3, 32'h0BADBAD4, 0, 0, 32'h0,        1, 32'h01000100, 1, 4'h7, 1);
    tbl_a[8]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h01000100, 1, 4'h7, 0);
    tbl_a[9]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h01000100, 1, 4'h7, 0);
    tbl_a[10] = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h02000200, 2, 4'h7, 0);

    tbl_c[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 4'h1, 0);
    tbl_c[1]  = mk(0, 0, 1, 1, 32'h01000500, 0, 0, 32'h0,        1, 32'h00400000, 0, 4'h1, 1);
    tbl_c[2]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h00400000, 0, 4'h1, 0);
    tbl_c[3]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h00000000, 0, 32'h0,        0, 4'h0, 0);
    tbl_c[4]  = mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h01000100, 1, 32'h01000100, 1, 4'h2, 0);
    tbl_c[5]  = mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 4'h2, 0);
    tbl_c[6]  = mk(0, 0, 1, 1, 32'h06000600, 1, 1, 32'h05000500, 1, 32'h05000500, 1, 4'h2, 0);
    tbl_c[7]  = mk(0, 0, 1, 1, 32'h07000700, 0, 0, 32'h0,        1, 32'h05000500, 1, 4'h2, 1);

    for (int i = 0; i < 11; i++) run_vec(tbl_a[i], "a", i);

    // Round-robin laps: slot1 is in flight and returns cross-hart; offers
    // already queued are slot2 then slot0. Each accepted offer retires the
    // next cycle at pc+4 and that retire is the next offer for its slot.
    sb_q.push_back('{slot: 2'd2, hpc: 32'h02000200});
    sb_q.push_back('{slot: 2'd0, hpc: 32'h00400004});
    ret_pend      = 1'b1;
    ret_item      = '{slot: 2'd1, hpc: 32'h03000104};
    exp_mask      = 4'h7;
    exp_mask_next = 4'h7;
    for (int cyc = 0; cyc < 24; cyc++) begin
      logic stall;
      logic park;
      stall = (cyc >= 5) && (cyc < 10);
      park  = (cyc >= 14);
      check($sformatf("b%0d_vld", cyc),   32'(sig_fetch_valid), 32'd1);
      check($sformatf("b%0d_stray", cyc), 32'(sig_stray_ret),   32'd0);
      check($sformatf("b%0d_mask", cyc),  32'(sig_active_mask), 32'(exp_mask));
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b%0d_sb_empty actual=offer required=queued_entry", cyc);
        front = '{slot: 2'd0, hpc: 32'h0};
      end else begin
        front = sb_q[0];
        check($sformatf("b%0d_slot", cyc), 32'(sig_fetch_slot), 32'(front.slot));
        check($sformatf("b%0d_hpc", cyc),  sig_fetch_hpc,       front.hpc);
      end
      tock_fetch_ready = !stall;
      tock_ret_valid   = ret_pend;
      tock_ret_slot    = ret_item.slot;
      tock_ret_hpc     = ret_item.hpc;
      if (ret_pend) begin
        if (park && (ret_item.slot == 2'd2)) begin
          tock_ret_hpc  = {ret_item.hpc[31:24], 24'h0};
          exp_mask_next = 4'h3;
        end else begin
          sb_q.push_back(ret_item);
        end
      end
      ret_pend = 1'b0;
      if (!stall && sb_q.size() != 0) begin
        ret_item = '{slot: front.slot, hpc: front.hpc + 32'd4};
        ret_pend = 1'b1;
        void'(sb_q.pop_front());
      end
      step();
      exp_mask = exp_mask_next;
    end
    tock_ret_valid = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl_c[i], "c", i);

`ifdef PINWHEEL_SCHED_PERF_EN
    tick_reset_in = 1'b1; tock_ret_valid = 1'b0; tock_dbg_wren = 1'b0; tock_fetch_ready = 1'b0;
    tock_perf_slot = 2'd0;
    step();
    tick_reset_in = 1'b0;
    step();
    for (int n = 0; n < 10; n++) begin
      check($sformatf("p%0d_vld", n), 32'(sig_fetch_valid), 32'd1);
      tock_fetch_ready = 1'b1;
      step();
      tock_fetch_ready = 1'b0;
      tock_ret_valid   = 1'b1;
      tock_ret_slot    = 2'd0;
      tock_ret_hpc     = 32'h00400000;
      step();
      tock_ret_valid   = 1'b0;
    end
    check("perf_cnt10", sig_perf_count, 32'd10);
    tock_perf_slot = 2'd1;
    #1;
    check("perf_cnt_slot1", sig_perf_count, 32'd0);
    tock_perf_slot = 2'd0;
    tock_dbg_wren  = 1'b1;
    tock_dbg_slot  = 2'd0;
    tock_dbg_hpc   = 32'h00400000;
    step();
    tock_dbg_wren  = 1'b0;
    check("perf_cnt_clr", sig_perf_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
